// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port instruction/data memory between the fetch path (IF)
// and the load/store path (D); one access in flight, results returned as rvalid pulses.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_IF = 2'd1;
  localparam logic [1:0] BUSY_D  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             if_win;
  logic             d_win;

  // Grants are only offered from IDLE; gating with rst_n keeps them low while reset is held.
  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    if_win = 1'b0;
    d_win  = 1'b0;
    if (rst_n && state == IDLE) begin
      if (if_req && (!d_req || starve_cnt == CNT_MAX)) begin
        if_win = 1'b1;
      end else if (d_req) begin
        d_win = 1'b1;
      end
    end
  end

  assign if_gnt  = if_win;
  assign d_gnt   = d_win;
  assign busy    = (state != IDLE);
  assign mem_req = busy;

  // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_win) begin
            state      <= BUSY_IF;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            mem_be     <= '1;
            starve_cnt <= '0;
          end else if (d_win) begin
            state     <= BUSY_D;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_we ? d_be : '1;
            // IF lost a contended round; count it towards its forced win.
            if (if_req && starve_cnt != CNT_MAX) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        BUSY_IF: begin
          if (mem_ack) begin
            if_rdata  <= mem_rdata;
            if_rvalid <= 1'b1;
            state     <= IDLE;
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
            d_rvalid <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: reset, table vectors, directed
// corner sequences and a randomized run against a cycle-count reference model.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;
  localparam int LIMIT  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              if_req, if_gnt, if_rvalid;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req, d_we, d_gnt, d_rvalid;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic [BE_W-1:0]   d_be;
  logic              mem_req, mem_we, mem_ack, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [BE_W-1:0]   mem_be;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents: one fixed instruction word, everything else derived from the address.
  function automatic logic [31:0] data_at(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  // Memory responder: acks after mem_wait extra cycles, or is overridden by force_* values.
  bit          mem_auto = 1'b1;
  int          mem_wait = 0;
  int          wait_cnt = 0;
  logic        auto_ack = 1'b0;
  logic [31:0] auto_rdata = '0;
  logic        force_ack = 1'b0;
  logic [31:0] force_rdata = '0;

  assign mem_ack   = mem_auto ? auto_ack : force_ack;
  assign mem_rdata = mem_auto ? auto_rdata : force_rdata;

  always @(posedge clk) begin
    #1;
    if (mem_req && wait_cnt == mem_wait) begin
      auto_ack   = 1'b1;
      auto_rdata = data_at(mem_addr);
      wait_cnt   = 0;
    end else if (mem_req) begin
      auto_ack = 1'b0;
      wait_cnt++;
    end else begin
      auto_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  typedef struct {
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        e_if_gnt, e_d_gnt, e_busy, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
  } vec_t;

  vec_t vecs[6];

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    mem_auto = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_ctl"}, {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we, busy, mem_be}, 64'h0);
    check({tag, "_if_rdata"}, if_rdata, 64'h0);
    check({tag, "_d_rdata"}, d_rdata, 64'h0);
    check({tag, "_mem_addr"}, mem_addr, 64'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 64'h0);
  endtask

  // Reference model state for the randomized run
  int          cyc, free_cyc, losses, ng, nr, w, t_done;
  int          gcyc[3];
  bit          ip, dp, dwe, idle, eg_if, eg_d, ev_if, ev_d;
  logic [31:0] ia, da, dw, e_if_rdata, e_d_rdata, x_addr, x_wdata;
  logic [3:0]  db, x_be;
  logic        x_we;
  logic [9:0]  order;

  typedef struct {
    int          cyc;
    bit          is_d;
    bit          is_store;
    logic [31:0] data;
  } cpl_t;
  cpl_t cq[$];
  cpl_t c;

  initial begin
    //            ifr   dr    we    if_addr  d_addr     d_wdata       be     gIF   gD    busy  we    addr       wdata         be
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h0,     32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     32'h0,        4'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0,     32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100,   32'h0,        4'hF};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h44,    32'h55AA55AA, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 32'h44,    32'h0,        4'hF};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h80,    32'h11223344, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 32'h80,    32'h11223344, 4'h5};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h104, 32'h200,   32'h0,        4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h200,   32'h0,        4'hF};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h108, 32'h2000,  32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2000,  32'hDEADBEEF, 4'hF};

    // Reset held with random inputs, then released with idle inputs
    clear_inputs();
    mem_auto = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if_req = 1'($urandom); if_addr = $urandom;
      d_req = 1'($urandom); d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
      force_ack = 1'($urandom); force_rdata = $urandom;
      @(negedge clk);
      outputs_zero("reset_hold");
    end
    @(posedge clk); #1;
    clear_inputs();
    force_ack = 1'b0;
    mem_auto = 1'b1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      outputs_zero("reset_release");
    end

    // Table vectors, each applied from a fresh reset for one cycle
    mem_wait = 1;
    for (int i = 0; i < 6; i++) begin
      do_reset();
      @(posedge clk); #1;
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_addr = vecs[i].d_addr;
      d_wdata = vecs[i].d_wdata; d_be = vecs[i].d_be;
      @(negedge clk);
      check($sformatf("vec%0d_gnt", i), {if_gnt, d_gnt}, {vecs[i].e_if_gnt, vecs[i].e_d_gnt});
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);
      check($sformatf("vec%0d_busy", i), {busy, mem_req}, {2{vecs[i].e_busy}});
      if (vecs[i].e_busy) begin
        check($sformatf("vec%0d_mem", i), {mem_we, mem_be, mem_addr}, {vecs[i].e_we, vecs[i].e_be, vecs[i].e_addr});
        if (vecs[i].e_we) check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].e_wdata);
        t_done = 0;
        while (t_done < 8 && !(if_rvalid || d_rvalid)) begin
          @(negedge clk);
          t_done++;
        end
        check($sformatf("vec%0d_rvalid", i), {if_rvalid, d_rvalid}, {vecs[i].e_if_gnt, vecs[i].e_d_gnt});
      end
    end

    // IF read with two memory wait cycles
    do_reset();
    mem_wait = 2;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    check("if_read_gnt", {if_gnt, d_gnt}, 2'b10);
    @(posedge clk); #1;
    if_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("if_read_c%0d", k), {mem_req, mem_we, if_rvalid, mem_addr}, {3'b100, 32'h100});
    end
    @(negedge clk);
    check("if_read_c4", {mem_req, if_rvalid, if_rdata}, {2'b01, 32'h0050_0093});
    @(negedge clk);
    check("if_read_c5", {mem_req, if_rvalid}, 2'b00);

    // Contended store: D wins, IF follows
    do_reset();
    mem_wait = 0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h500;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'hF;
    @(negedge clk);
    check("store_gnt", {if_gnt, d_gnt}, 2'b01);
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    check("store_mem", {mem_req, mem_we, mem_be, if_gnt, mem_addr}, {1'b1, 1'b1, 4'hF, 1'b0, 32'h2000});
    check("store_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    check("store_done", {d_rvalid, if_gnt, d_rdata}, {2'b11, 32'h0});
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    check("store_if_next", {d_rvalid, mem_we, mem_addr}, {2'b00, 32'h500});
    @(negedge clk);
    check("store_if_rdata", {if_rvalid, if_rdata}, {1'b1, data_at(32'h500)});

    // Starvation with both requests held high
    do_reset();
    mem_wait = 0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h400; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    ng = 0;
    order = '0;
    for (int t = 0; t < 40 && ng < 10; t++) begin
      @(negedge clk);
      check("starve_excl", {if_gnt & d_gnt, if_rvalid & d_rvalid}, 2'b00);
      if ((if_gnt || d_gnt) && ng < 10) begin
        order[ng] = if_gnt;
        ng++;
      end
    end
    check("starve_grants", ng, 10);
    check("starve_order", order, 10'b10_0001_0000);

    // Reset in the middle of a D access; a late ack must be ignored
    do_reset();
    mem_auto = 1'b0;
    force_ack = 1'b0;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    @(negedge clk);
    check("midrst_gnt", d_gnt, 1'b1);
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    check("midrst_busy", {mem_req, busy}, 2'b11);
    #2 rst_n = 1'b0;
    #1 check("midrst_drop", {mem_req, busy, d_rvalid}, 3'b000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    force_ack = 1'b1; force_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    check("midrst_stale1", {mem_req, busy, d_rvalid, d_gnt}, 4'b0000);
    @(posedge clk); #1;
    force_ack = 1'b0;
    @(negedge clk);
    check("midrst_stale2", {mem_req, busy, d_rvalid, d_rdata}, {3'b000, 32'h0});
    mem_auto = 1'b1;

    // Back-to-back zero-wait loads
    do_reset();
    mem_wait = 0;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    ng = 0;
    nr = 0;
    for (int t = 0; t < 20 && nr < 3; t++) begin
      @(negedge clk);
      if (d_rvalid && nr < 3) begin
        check($sformatf("b2b_rdata%0d", nr), d_rdata, data_at(32'h10 + 32'(4 * nr)));
        check($sformatf("b2b_lat%0d", nr), t, gcyc[nr] + 2);
        nr++;
      end
      if (d_gnt && ng < 3) begin
        gcyc[ng] = t;
        ng++;
      end
      @(posedge clk); #1;
      if (ng == 3) d_req = 1'b0;
      else d_addr = 32'h10 + 32'(4 * ng);
    end
    check("b2b_counts", {ng[7:0], nr[7:0]}, {8'd3, 8'd3});
    check("b2b_gap01", gcyc[1] - gcyc[0], 2);
    check("b2b_gap12", gcyc[2] - gcyc[1], 2);

    // Randomized traffic against the reference model
    do_reset();
    cyc = 0; free_cyc = 0; losses = 0;
    ip = 1'b0; dp = 1'b0;
    e_if_rdata = '0; e_d_rdata = '0;
    x_we = 1'b0; x_addr = '0; x_wdata = '0; x_be = '0;
    cq.delete();
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (!ip && k < 390 && $urandom_range(0, 3) != 0) begin
        ip = 1'b1;
        ia = 32'($urandom_range(0, 255)) << 2;
      end
      if (!dp && k < 390 && $urandom_range(0, 2) != 0) begin
        dp = 1'b1;
        dwe = 1'($urandom);
        da = $urandom & 32'h0000_FFFC;
        dw = $urandom;
        db = 4'($urandom_range(1, 15));
      end
      if_req = ip; if_addr = ia;
      d_req = dp; d_we = dwe; d_addr = da; d_wdata = dw; d_be = db;
      @(negedge clk);
      idle  = (cyc >= free_cyc);
      eg_if = idle && ip && (!dp || losses == LIMIT);
      eg_d  = idle && dp && !eg_if;
      check("rnd_gnt", {if_gnt, d_gnt}, {eg_if, eg_d});
      ev_if = 1'b0;
      ev_d  = 1'b0;
      if (cq.size() > 0 && cq[0].cyc == cyc) begin
        c = cq.pop_front();
        if (c.is_d) begin
          ev_d = 1'b1;
          if (!c.is_store) e_d_rdata = c.data;
        end else begin
          ev_if = 1'b1;
          e_if_rdata = c.data;
        end
      end
      check("rnd_rvalid", {if_rvalid, d_rvalid}, {ev_if, ev_d});
      check("rnd_rdata", {if_rdata, d_rdata}, {e_if_rdata, e_d_rdata});
      check("rnd_busy", {busy, mem_req}, {2{!idle}});
      if (!idle) begin
        check("rnd_mem", {mem_we, mem_be, mem_addr}, {x_we, x_be, x_addr});
        if (x_we) check("rnd_wdata", mem_wdata, x_wdata);
      end
      if (eg_if || eg_d) begin
        w = $urandom_range(0, 2);
        mem_wait = w;
        free_cyc = cyc + 2 + w;
        c.cyc = free_cyc;
        c.is_d = eg_d;
        c.is_store = eg_d && dwe;
        c.data = eg_d ? data_at(da) : data_at(ia);
        cq.push_back(c);
        x_we    = eg_d && dwe;
        x_addr  = eg_d ? da : ia;
        x_wdata = dw;
        x_be    = (eg_d && dwe) ? db : 4'hF;
        if (eg_if) begin
          losses = 0;
          ip = 1'b0;
        end else begin
          if (ip && losses < LIMIT) losses++;
          dp = 1'b0;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
